// File: rtl/axil_lite_master_if.sv
// AXI4-Lite bus bundle between an initiator and a target.
interface axil_lite_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   M_AXI_AWADDR;
    logic [2:0]          M_AXI_AWPROT;
    logic                M_AXI_AWVALID;
    logic                M_AXI_AWREADY;
    logic [DATA_W-1:0]   M_AXI_WDATA;
    logic [DATA_W/8-1:0] M_AXI_WSTRB;
    logic                M_AXI_WVALID;
    logic                M_AXI_WREADY;
    logic [1:0]          M_AXI_BRESP;
    logic                M_AXI_BVALID;
    logic                M_AXI_BREADY;
    logic [ADDR_W-1:0]   M_AXI_ARADDR;
    logic [2:0]          M_AXI_ARPROT;
    logic                M_AXI_ARVALID;
    logic                M_AXI_ARREADY;
    logic [DATA_W-1:0]   M_AXI_RDATA;
    logic [1:0]          M_AXI_RRESP;
    logic                M_AXI_RVALID;
    logic                M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axil_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI read or
// write out, one response back. Each AXI phase is guarded by a timeout that
// aborts the transaction with SLVERR instead of hanging on a silent slave.
module axil_lite_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    axil_lite_master_if.master  m_axi
);

    localparam int unsigned StrbW = DATA_W / 8;
    localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TmoEn = (TIMEOUT != 0);
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT - 1);
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrResp,
        StRdAddr,
        StRdData,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [StrbW-1:0]  wstrb_q, wstrb_d;

    logic aw_hs, w_hs, aw_left, w_left;
    logic tmo_hit, abort;

    // Counter sits at TIMEOUT-1 during the last permitted waiting cycle.
    assign tmo_hit = TmoEn && (cnt_q == TmoLast);

    // Next-state, handshake tracking and timeout abort.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        abort         = 1'b0;
        aw_hs         = awvalid_q && m_axi.M_AXI_AWREADY;
        w_hs          = wvalid_q && m_axi.M_AXI_WREADY;
        aw_left       = awvalid_q && !aw_hs;
        w_left        = wvalid_q && !w_hs;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    cmd_ready_d = 1'b0;
                    cnt_d       = '0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWr;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRdAddr;
                    end
                end else begin
                    // Also raises cmd_ready on the first cycle out of reset.
                    cmd_ready_d = 1'b1;
                end
            end
            StWr: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                end
                if (!aw_left && !w_left) begin
                    bready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StWrResp;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWrResp: begin
                if (m_axi.M_AXI_BVALID && bready_q) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axi.M_AXI_BRESP;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRdAddr: begin
                if (arvalid_q && m_axi.M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = StRdData;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRdData: begin
                if (m_axi.M_AXI_RVALID && rready_q) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = m_axi.M_AXI_RDATA;
                    rsp_resp_d    = m_axi.M_AXI_RRESP;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Protocol-abort recovery: release the bus and report SLVERR.
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = RespSlvErr;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
            state_d       = StResp;
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = wstrb_q;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_lite_master.sv
// Bench for axil_lite_master: a memory-backed AXI-Lite slave with random
// per-phase delays, a command-level memory model for expected data, and a
// second instance with a short timeout facing a slave that never answers.
module tb_axil_lite_master;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    logic        c2_valid, c2_ready, c2_write;
    logic [31:0] c2_addr, c2_wdata;
    logic [3:0]  c2_wstrb;
    logic        c2_rsp_valid, c2_rsp_ready, c2_rsp_timeout;
    logic [31:0] c2_rsp_rdata;
    logic [1:0]  c2_rsp_resp;

    axil_lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    axil_lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    axil_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(1024)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .m_axi(bus)
    );

    axil_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut_tmo (
        .clk(clk), .resetn(resetn),
        .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_write(c2_write),
        .cmd_addr(c2_addr), .cmd_wdata(c2_wdata), .cmd_wstrb(c2_wstrb),
        .rsp_valid(c2_rsp_valid), .rsp_ready(c2_rsp_ready), .rsp_rdata(c2_rsp_rdata),
        .rsp_resp(c2_rsp_resp), .rsp_timeout(c2_rsp_timeout), .m_axi(bus2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave configuration and memories (slave side and command-level model).
    bit [31:0]  smem[16];
    bit [31:0]  mmem[16];
    int         s_aw_dly, s_w_dly, s_b_dly, s_ar_dly, s_r_dly;
    logic [1:0] s_code;
    bit         s_arm;
    int         viol;
    logic [31:0] s_awaddr, s_araddr, s_wdata;
    logic [3:0]  s_wstrb;

    // Slave: all decisions at negedge, from values stable since the posedge.
    // st: 0 waiting, 1 handshake at next posedge, 2 done, 3 presented.
    initial begin
        int aw_st, w_st, b_st, ar_st, r_st;
        int aw_c, w_c, b_c, ar_c, r_c;
        bit aw_seen, w_seen, ar_seen;
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
        bus.M_AXI_BRESP = 0; bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0;
        bus.M_AXI_RDATA = 0; bus.M_AXI_RRESP = 0;
        aw_st = 2; w_st = 2; b_st = 2; ar_st = 2; r_st = 2;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        forever begin
            @(negedge clk);
            if (s_arm) begin
                s_arm = 0;
                aw_st = 0; w_st = 0; b_st = 0; ar_st = 0; r_st = 0;
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
                aw_seen = 0; w_seen = 0; ar_seen = 0;
                bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
                bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0;
            end
            // AW
            if (aw_st == 1) begin aw_st = 2; bus.M_AXI_AWREADY = 0; end
            if (aw_st == 2 && bus.M_AXI_AWVALID) viol++;
            if (aw_st == 0) begin
                if (bus.M_AXI_AWVALID) begin
                    aw_seen = 1;
                    if (aw_c >= s_aw_dly) begin
                        bus.M_AXI_AWREADY = 1; aw_st = 1; s_awaddr = bus.M_AXI_AWADDR;
                    end else aw_c++;
                end else if (aw_seen) viol++;
            end
            // W
            if (w_st == 1) begin w_st = 2; bus.M_AXI_WREADY = 0; end
            if (w_st == 2 && bus.M_AXI_WVALID) viol++;
            if (w_st == 0) begin
                if (bus.M_AXI_WVALID) begin
                    w_seen = 1;
                    if (w_c >= s_w_dly) begin
                        bus.M_AXI_WREADY = 1; w_st = 1;
                        s_wdata = bus.M_AXI_WDATA; s_wstrb = bus.M_AXI_WSTRB;
                    end else w_c++;
                end else if (w_seen) viol++;
            end
            // B: BREADY must not rise before both write handshakes are done
            if (b_st == 1) begin b_st = 2; bus.M_AXI_BVALID = 0; end
            if (bus.M_AXI_BREADY && !(aw_st == 2 && w_st == 2)) viol++;
            if (b_st == 2 && bus.M_AXI_BREADY) viol++;
            if (b_st == 0 && aw_st == 2 && w_st == 2) begin
                if (b_c >= s_b_dly) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) smem[s_awaddr[5:2]][b*8 +: 8] = s_wdata[b*8 +: 8];
                    bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = s_code; b_st = 3;
                end else b_c++;
            end
            if (b_st == 3 && bus.M_AXI_BREADY) b_st = 1;
            // AR
            if (ar_st == 1) begin ar_st = 2; bus.M_AXI_ARREADY = 0; end
            if (ar_st == 2 && bus.M_AXI_ARVALID) viol++;
            if (ar_st == 0) begin
                if (bus.M_AXI_ARVALID) begin
                    ar_seen = 1;
                    if (ar_c >= s_ar_dly) begin
                        bus.M_AXI_ARREADY = 1; ar_st = 1; s_araddr = bus.M_AXI_ARADDR;
                    end else ar_c++;
                end else if (ar_seen) viol++;
            end
            // R
            if (r_st == 1) begin r_st = 2; bus.M_AXI_RVALID = 0; end
            if (bus.M_AXI_RREADY && ar_st != 2) viol++;
            if (r_st == 2 && bus.M_AXI_RREADY) viol++;
            if (r_st == 0 && ar_st == 2) begin
                if (r_c >= s_r_dly) begin
                    bus.M_AXI_RVALID = 1; bus.M_AXI_RDATA = smem[s_araddr[5:2]];
                    bus.M_AXI_RRESP = s_code; r_st = 3;
                end else r_c++;
            end
            if (r_st == 3 && bus.M_AXI_RREADY) r_st = 1;
        end
    end

    function automatic logic axi_busy();
        return bus.M_AXI_AWVALID | bus.M_AXI_WVALID | bus.M_AXI_BREADY |
               bus.M_AXI_ARVALID | bus.M_AXI_RREADY;
    endfunction

    // One full transaction on the main instance, checked against the model.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int d_addr, input int d_w,
                           input int d_resp, input logic [1:0] code, input int hold);
        logic [31:0] exp_rdata;
        logic [34:0] snap;
        int n, lat, chg, busy;
        s_aw_dly = d_addr; s_ar_dly = d_addr; s_w_dly = d_w;
        s_b_dly = d_resp; s_r_dly = d_resp; s_code = code;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mmem[addr[5:2]][b*8 +: 8] = data[b*8 +: 8];
            exp_rdata = 32'h0;
        end else begin
            exp_rdata = mmem[addr[5:2]];
        end
        n = 0;
        while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
        if (!cmd_ready) begin check_eq("cmd_ready_wait", 0, 1); return; end
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        s_arm = 1;
        @(negedge clk);
        cmd_valid = 0;
        lat = 1;
        check_eq("cmd_ready_drop", cmd_ready, 0);
        while (!rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
        if (!rsp_valid) begin check_eq("rsp_wait", 0, 1); return; end
        if (d_addr == 0 && d_w == 0 && d_resp == 0) check_eq("latency", lat, 3);
        check_eq(wr ? "wr_rdata" : "rd_rdata", rsp_rdata, exp_rdata);
        check_eq("rsp_resp", rsp_resp, code);
        check_eq("rsp_timeout", rsp_timeout, 0);
        check_eq("axi_addr", wr ? s_awaddr : s_araddr, addr);
        if (wr) check_eq("axi_wdata", {s_wstrb, s_wdata}, {strb, data});
        // Hold the response while offering a command that must not be taken.
        snap = {rsp_valid, rsp_rdata, rsp_resp};
        chg = 0; busy = 0;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hFC;
            @(negedge clk);
            if ({rsp_valid, rsp_rdata, rsp_resp} !== snap || rsp_timeout !== 1'b0) chg++;
            if (axi_busy() || cmd_ready) busy++;
        end
        if (hold > 0) begin
            check_eq("rsp_stable", chg, 0);
            check_eq("hold_quiet", busy, 0);
        end
        cmd_valid = 0;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check_eq("rsp_consumed", {rsp_valid, cmd_ready}, 2'b01);
        check_eq("protocol", viol, 0);
        viol = 0;
    endtask

    // Timeout instance: the slave side never answers.
    task automatic tmo_txn(input bit wr);
        int n, hi;
        n = 0;
        while (!c2_ready && n < 100) begin @(negedge clk); n++; end
        c2_valid = 1; c2_write = wr; c2_addr = 32'h40; c2_wdata = 32'h1234; c2_wstrb = 4'hF;
        @(negedge clk);
        c2_valid = 0;
        hi = 0; n = 0;
        while ((wr ? bus2.M_AXI_AWVALID : bus2.M_AXI_ARVALID) && n < 100) begin
            hi++; @(negedge clk); n++;
        end
        check_eq(wr ? "tmo_wr_cycles" : "tmo_rd_cycles", hi, 16);
        check_eq("tmo_bus_idle", {bus2.M_AXI_AWVALID, bus2.M_AXI_WVALID, bus2.M_AXI_BREADY,
                                  bus2.M_AXI_ARVALID, bus2.M_AXI_RREADY}, 0);
        check_eq("tmo_rsp", {c2_rsp_valid, c2_rsp_resp, c2_rsp_timeout, c2_rsp_rdata},
                 {1'b1, 2'b10, 1'b1, 32'h0});
        c2_rsp_ready = 1;
        @(negedge clk);
        c2_rsp_ready = 0;
        check_eq("tmo_cmd_ready", {c2_rsp_valid, c2_ready}, 2'b01);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        int n;
        resetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; c2_valid = 0; c2_write = 0; c2_addr = 0; c2_wdata = 0; c2_wstrb = 0;
        c2_rsp_ready = 0; s_arm = 0; viol = 0; s_code = 0;
        s_aw_dly = 0; s_w_dly = 0; s_b_dly = 0; s_ar_dly = 0; s_r_dly = 0;
        bus2.M_AXI_AWREADY = 0; bus2.M_AXI_WREADY = 0; bus2.M_AXI_BVALID = 0;
        bus2.M_AXI_BRESP = 2'b00; bus2.M_AXI_ARREADY = 0; bus2.M_AXI_RVALID = 0;
        bus2.M_AXI_RDATA = 32'hFFFF_FFFF; bus2.M_AXI_RRESP = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("rst_ctrl", {cmd_ready, rsp_valid, rsp_resp, rsp_timeout, axi_busy()}, 0);
        check_eq("rst_data", |{rsp_rdata, bus.M_AXI_AWADDR, bus.M_AXI_ARADDR,
                               bus.M_AXI_WDATA, bus.M_AXI_WSTRB}, 0);
        check_eq("prot", {bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}, 0);
        resetn = 1;
        @(negedge clk);
        check_eq("ready_after_rst", cmd_ready, 1);

        // Directed: plain read returning 0x2A.
        run_txn(1, 32'h20, 32'h0000_002A, 4'hF, 0, 0, 0, 2'b00, 0);
        run_txn(0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0);
        // Write with WREADY two cycles ahead of AWREADY and SLVERR.
        run_txn(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2, 0, 0, 2'b10, 0);
        run_txn(0, 32'h10, 32'h0, 4'h0, 0, 2, 1, 2'b00, 0);
        // Long ARREADY stall, well inside the timeout.
        run_txn(0, 32'h10, 32'h0, 4'h0, 500, 0, 0, 2'b00, 0);
        // Held response, then back-to-back read and write.
        run_txn(0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 2'b00, 10);
        run_txn(1, 32'h24, 32'h5555_AAAA, 4'h5, 0, 0, 0, 2'b00, 0);
        run_txn(0, 32'h24, 32'h0, 4'h0, 0, 0, 0, 2'b01, 0);

        // Timeouts on the short-timeout instance.
        tmo_txn(0);
        tmo_txn(1);

        // Reset pulse while waiting in the read-data phase.
        s_ar_dly = 0; s_r_dly = 20; s_code = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h18;
        s_arm = 1;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!bus.M_AXI_RREADY && n < 10) begin @(negedge clk); n++; end
        check_eq("reached_rd_data", bus.M_AXI_RREADY, 1);
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        check_eq("midrst_ctrl", {cmd_ready, rsp_valid, rsp_resp, rsp_timeout, axi_busy()}, 0);
        check_eq("midrst_data", |{rsp_rdata, bus.M_AXI_ARADDR, bus.M_AXI_AWADDR}, 0);
        s_arm = 1;
        viol = 0;
        @(negedge clk);
        run_txn(0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            a = ($urandom() & 32'h0000_FF00) | (32'($urandom_range(0, 15)) << 2);
            d = $urandom();
            if ($urandom_range(0, 3) == 0)
                run_txn($urandom_range(0, 1) == 1, a, d, 4'($urandom()), 0, 0, 0,
                        2'($urandom()), 0);
            else
                run_txn($urandom_range(0, 1) == 1, a, d, 4'($urandom()),
                        $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                        2'($urandom()), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
